// File: rtl/fpu_fmul_param_if.sv
// Operand/result bundle between the FPU issue logic and the parametrised multiplier.
// The requester drives operands and handshakes; the multiplier returns result and flags.
interface fpu_fmul_param_if #(
  parameter int EXPBITS = 8,
  parameter int MANBITS = 23
);
  localparam int FP = 1 + EXPBITS + MANBITS;

  logic [FP-1:0] float_0_in;
  logic [FP-1:0] float_1_in;
  logic          req_in;
  logic          rnd_mode_in;
  logic          ack_in;
  logic          busy_out;
  logic [FP-1:0] float_answer_out;
  logic          ready_answer_out;
  logic          overflow_out;
  logic          underflow_out;
  logic          invalid_out;
  logic [2:0]    state_out;

  modport master (
    output float_0_in, float_1_in, req_in, rnd_mode_in, ack_in,
    input  busy_out, float_answer_out, ready_answer_out,
           overflow_out, underflow_out, invalid_out, state_out
  );

  modport slave (
    input  float_0_in, float_1_in, req_in, rnd_mode_in, ack_in,
    output busy_out, float_answer_out, ready_answer_out,
           overflow_out, underflow_out, invalid_out, state_out
  );
endinterface

// File: rtl/fpu_fmul_param.sv
// Multi-cycle parametrised floating-point multiplier with RNE/truncate rounding,
// flush-to-zero of subnormals, saturation flags and a result/ack handshake.
module fpu_fmul_param #(
  parameter int EXPBITS = 8,
  parameter int MANBITS = 23
) (
  input logic             clk,
  input logic             rst,
  fpu_fmul_param_if.slave bus
);
  localparam int FP       = 1 + EXPBITS + MANBITS;
  localparam int SIGBITS  = MANBITS + 1;
  localparam int PRODBITS = 2 * SIGBITS;
  localparam int EXPW     = EXPBITS + 2;

  localparam logic signed [EXPW-1:0] BIAS    = EXPW'((1 << (EXPBITS - 1)) - 1);
  localparam logic signed [EXPW-1:0] EXP_MAX = EXPW'((1 << EXPBITS) - 1);
  localparam logic signed [EXPW-1:0] EXP_ONE = EXPW'(1);
  localparam logic [FP-1:0]          QNAN    = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(MANBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_MULTIPLY  = 3'd2,
    S_NORMALIZE = 3'd3,
    S_ROUND     = 3'd4,
    S_OUTPUT    = 3'd5,
    S_ERROR     = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [FP-1:0]          op_a, op_b;
  logic                   rnd_trunc;
  logic                   is_zero;
  logic                   sign_r;
  logic [1:0]             err_cnt;
  logic signed [EXPW-1:0] exp_r;
  logic [PRODBITS-1:0]    prod_r;
  logic [MANBITS-1:0]     man_r;
  logic                   guard_r, sticky_r;

  logic [EXPBITS-1:0] exp_a, exp_b;
  logic [MANBITS-1:0] man_a, man_b;

  assign exp_a = op_a[FP-2 -: EXPBITS];
  assign exp_b = op_b[FP-2 -: EXPBITS];
  assign man_a = op_a[MANBITS-1:0];
  assign man_b = op_b[MANBITS-1:0];

  // NOTE: state and every other register update with <= so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.req_in) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = (&exp_a || &exp_b) ? S_ERROR : S_MULTIPLY;
      S_MULTIPLY:  state_nxt = S_NORMALIZE;
      S_NORMALIZE: state_nxt = S_ROUND;
      S_ROUND:     state_nxt = S_OUTPUT;
      S_ERROR:     if (err_cnt == 2'd2) state_nxt = S_OUTPUT;
      S_OUTPUT:    if (bus.ack_in) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Product lies in [1,4): leading one at the top bit means one extra exponent step.
  logic               norm_shift;
  logic [MANBITS-1:0] man_norm;
  logic               guard_norm, sticky_norm;

  always_comb begin
    norm_shift  = prod_r[PRODBITS-1];
    man_norm    = norm_shift ? prod_r[PRODBITS-2 -: MANBITS] : prod_r[PRODBITS-3 -: MANBITS];
    guard_norm  = norm_shift ? prod_r[MANBITS] : prod_r[MANBITS-1];
    sticky_norm = norm_shift ? |prod_r[MANBITS-1:0] : |prod_r[MANBITS-2:0];
  end

  logic                   round_inc;
  logic [MANBITS:0]       man_rounded;
  logic signed [EXPW-1:0] exp_rounded;

  always_comb begin
    round_inc   = !rnd_trunc && guard_r && (sticky_r || man_r[0]);
    man_rounded = {1'b0, man_r} + (MANBITS+1)'(round_inc);
    // A carry-out leaves the low mantissa bits at zero, so only the exponent moves.
    exp_rounded = man_rounded[MANBITS] ? exp_r + EXP_ONE : exp_r;
  end

  // NOTE: datapath registers carry no reset; each is written before it is read on every pass.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (bus.req_in) begin
          op_a      <= bus.float_0_in;
          op_b      <= bus.float_1_in;
          rnd_trunc <= bus.rnd_mode_in;
        end
      end
      S_LOAD: begin
        is_zero <= (exp_a == '0) || (exp_b == '0);
        err_cnt <= 2'd0;
      end
      S_MULTIPLY: begin
        prod_r <= PRODBITS'({1'b1, man_a}) * PRODBITS'({1'b1, man_b});
        exp_r  <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
        sign_r <= op_a[FP-1] ^ op_b[FP-1];
      end
      S_NORMALIZE: begin
        man_r    <= man_norm;
        guard_r  <= guard_norm;
        sticky_r <= sticky_norm;
        if (norm_shift) exp_r <= exp_r + EXP_ONE;
      end
      S_ERROR: err_cnt <= err_cnt + 2'd1;
      default: ;
    endcase
  end

  logic [FP-1:0] answer_r;
  logic          ovf_r, unf_r, inv_r;

  // Results are written only on OUTPUT entry and held through IDLE until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      answer_r <= '0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else if (state == S_ROUND) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      inv_r <= 1'b0;
      if (is_zero) begin
        answer_r <= {sign_r, {(FP-1){1'b0}}};
      end else if (exp_rounded >= EXP_MAX) begin
        answer_r <= {sign_r, {EXPBITS{1'b1}}, {MANBITS{1'b0}}};
        ovf_r    <= 1'b1;
      end else if (exp_rounded < EXP_ONE) begin
        answer_r <= {sign_r, {(FP-1){1'b0}}};
        unf_r    <= 1'b1;
      end else begin
        answer_r <= {sign_r, exp_rounded[EXPBITS-1:0], man_rounded[MANBITS-1:0]};
      end
    end else if (state == S_ERROR && err_cnt == 2'd2) begin
      answer_r <= QNAN;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      inv_r    <= 1'b1;
    end
  end

  assign bus.float_answer_out = answer_r;
  assign bus.overflow_out     = ovf_r;
  assign bus.underflow_out    = unf_r;
  assign bus.invalid_out      = inv_r;
  assign bus.busy_out         = (state != S_IDLE);
  assign bus.ready_answer_out = (state == S_OUTPUT);
  assign bus.state_out        = state;
endmodule

// File: tb/tb_fpu_fmul_param.sv
// Self-checking bench for fpu_fmul_param (single precision): directed literal cases
// plus randomized operations against a cycle-level behavioural model.
module tb_fpu_fmul_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_fmul_param_if #(.EXPBITS(8), .MANBITS(23)) bus ();

  fpu_fmul_param #(.EXPBITS(8), .MANBITS(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inv;
  } ref_t;

  // Reference multiply from the arithmetic rules: exact integer product, remainder-based rounding.
  function automatic ref_t ref_mul(input logic [31:0] a, input logic [31:0] b, input logic trunc);
    ref_t r;
    longint unsigned sa, sb, p, kept, rem, half;
    int e, shift;
    logic s;
    r = '0;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      r.res = 32'h7fc00000;
      r.inv = 1'b1;
      return r;
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      r.res = {s, 31'b0};
      return r;
    end
    sa = 64'({1'b1, a[22:0]});
    sb = 64'({1'b1, b[22:0]});
    p  = sa * sb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    shift = 23;
    if (p >= (64'd1 << 47)) begin
      shift = 24;
      e++;
    end
    kept = p >> shift;
    rem  = p - (kept << shift);
    half = 64'd1 << (shift - 1);
    if (!trunc && (rem > half || (rem == half && kept[0]))) kept++;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) begin
      r.res = {s, 8'hff, 23'b0};
      r.ovf = 1'b1;
    end else if (e < 1) begin
      r.res = {s, 31'b0};
      r.unf = 1'b1;
    end else begin
      r.res = {s, 8'(e), kept[22:0]};
    end
    return r;
  endfunction

  // Latency model: phase 0 idle, 1..4 in flight, 5 holding the result until ack.
  int          m_phase;
  logic [31:0] m_a, m_b;
  logic        m_trunc;
  ref_t        m_exp;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_exp   <= '0;
    end else begin
      case (m_phase)
        0: if (bus.req_in) begin
          m_phase <= 1;
          m_a     <= bus.float_0_in;
          m_b     <= bus.float_1_in;
          m_trunc <= bus.rnd_mode_in;
        end
        5: if (bus.ack_in) m_phase <= 0;
        default: begin
          m_phase <= m_phase + 1;
          if (m_phase == 4) m_exp <= ref_mul(m_a, m_b, m_trunc);
        end
      endcase
    end
  end

  function automatic logic [2:0] exp_state(input int phase, input logic special);
    if (phase == 0) return 3'd0;
    if (special && phase >= 2 && phase <= 4) return 3'd7;
    return 3'(phase);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic special;
      special = (m_a[30:23] == 8'hff) || (m_b[30:23] == 8'hff);
      check("state", 32'(bus.state_out), 32'(exp_state(m_phase, special)));
      check("busy", 32'(bus.busy_out), 32'(m_phase != 0));
      check("ready", 32'(bus.ready_answer_out), 32'(m_phase == 5));
      check("result", bus.float_answer_out, m_exp.res);
      check("flags", 32'({bus.overflow_out, bus.underflow_out, bus.invalid_out}),
            32'({m_exp.ovf, m_exp.unf, m_exp.inv}));
    end
  end

  // Called one step after a posedge with the DUT idle; returns once it is idle again.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic trunc,
                        input int ack_wait, output logic [31:0] res, output logic [2:0] flags);
    int lat;
    bus.float_0_in  = a;
    bus.float_1_in  = b;
    bus.rnd_mode_in = trunc;
    bus.req_in      = 1'b1;
    bus.ack_in      = (ack_wait == 0);
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    lat = 1;
    while (!bus.ready_answer_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    res   = bus.float_answer_out;
    flags = {bus.overflow_out, bus.underflow_out, bus.invalid_out};
    if (ack_wait > 0) begin
      for (int i = 0; i < ack_wait; i++) begin
        bus.req_in     = (i == 1);
        bus.float_0_in = $urandom;
        @(posedge clk); #1;
        check("bp_ready", 32'(bus.ready_answer_out), 32'd1);
        check("bp_busy", 32'(bus.busy_out), 32'd1);
      end
      bus.req_in = 1'b0;
      bus.ack_in = 1'b1;
    end
    @(posedge clk); #1;
    bus.ack_in = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hff;
      2, 3:    v[30:23] = 8'($urandom_range(190, 254));
      4, 5:    v[30:23] = 8'($urandom_range(1, 64));
      6:       begin v[30:23] = 8'($urandom_range(110, 140)); v[22:0] = 23'h7fffff; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    ref_t        pin;
    bus.float_0_in  = '0;
    bus.float_1_in  = '0;
    bus.req_in      = 1'b0;
    bus.rnd_mode_in = 1'b0;
    bus.ack_in      = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_state", 32'(bus.state_out), 32'd0);
    check("rst_answer", bus.float_answer_out, 32'd0);
    check("rst_flags", 32'({bus.overflow_out, bus.underflow_out, bus.invalid_out}), 32'd0);

    // Pin the reference model on the rounding case before trusting it.
    pin = ref_mul(32'h3fc00001, 32'h3f800001, 1'b0);
    check("model_rne", pin.res, 32'h3fc00003);
    pin = ref_mul(32'h7f000000, 32'h7f000000, 1'b0);
    check("model_ovf", 32'({pin.res, pin.ovf}), 32'({32'h7f800000, 1'b1}));

    run_op(32'h3f800000, 32'h3f800000, 1'b0, 0, r, f);
    check("one_x_one", r, 32'h3f800000);
    check("one_x_one_flags", 32'(f), 32'd0);

    run_op(32'h41700000, 32'hc1a00000, 1'b0, 0, r, f);
    check("m15_x_m20", r, 32'hc3960000);
    run_op(32'hc1d00000, 32'h41f80000, 1'b0, 0, r, f);
    check("b2b_m26_x_31", r, 32'hc4498000);

    run_op(32'h3fc00001, 32'h3f800001, 1'b0, 0, r, f);
    check("round_rne", r, 32'h3fc00003);
    run_op(32'h3fc00001, 32'h3f800001, 1'b1, 0, r, f);
    check("round_trunc", r, 32'h3fc00002);

    run_op(32'h7f000000, 32'h7f000000, 1'b0, 0, r, f);
    check("overflow_res", r, 32'h7f800000);
    check("overflow_flag", 32'(f), 32'b100);
    run_op(32'h00800000, 32'h80800000, 1'b0, 0, r, f);
    check("underflow_res", r, 32'h80000000);
    check("underflow_flag", 32'(f), 32'b010);
    run_op(32'h00000000, 32'h3f800000, 1'b0, 0, r, f);
    check("zero_res", r, 32'h00000000);
    check("zero_flags", 32'(f), 32'd0);

    run_op(32'h7fc00000, 32'h3f800000, 1'b0, 0, r, f);
    check("nan_res", r, 32'h7fc00000);
    check("nan_flag", 32'(f), 32'b001);

    run_op(32'h41700000, 32'hc1a00000, 1'b0, 4, r, f);
    check("backpressure_res", r, 32'hc3960000);

    // Abort in NORMALIZE: everything must read zero on the next cycle.
    bus.float_0_in = 32'h40400000;
    bus.float_1_in = 32'h40400000;
    bus.req_in     = 1'b1;
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_state", 32'(bus.state_out), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", 32'(bus.state_out), 32'd0);
    check("abort_answer", bus.float_answer_out, 32'd0);
    check("abort_outs", 32'({bus.busy_out, bus.ready_answer_out, bus.overflow_out,
                             bus.underflow_out, bus.invalid_out}), 32'd0);

    for (int i = 0; i < 300; i++) begin
      run_op(rand_op(), rand_op(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), r, f);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
